// File: rtl/uart_rx_deserializer_pkg.sv
// Shared definitions for the UART receive path: FSM encodings, parity select
// values and the small combinational helpers used by the receiver.
package uart_rx_deserializer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    // data_xor is the reduction XOR of the received word.
    function automatic logic expected_parity(input logic typ, input logic data_xor);
        logic p;
        p = data_xor;
        case (typ)
            PARITY_EVEN: p = data_xor;
            PARITY_ODD:  p = ~data_xor;
            default:     p = data_xor;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Receive-side bundle: serial line and frame options in, recovered word and
// result pulses out.
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_deserializer_sampler.sv
// Three-point mid-bit sampler: captures RX_IN around the bit centre and
// presents the majority vote.
module uart_rx_sampler
    import uart_rx_deserializer_pkg::*;
#(
    parameter int OVERSAMPLE = 8,
    parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX_IN,
    input  logic [CNT_W-1:0] edge_cnt,
    input  logic             enable,
    output logic             sampled_bit
);

    localparam logic [CNT_W-1:0] EDGE_S0 = CNT_W'(OVERSAMPLE/2 - 1);
    localparam logic [CNT_W-1:0] EDGE_S1 = CNT_W'(OVERSAMPLE/2);
    localparam logic [CNT_W-1:0] EDGE_S2 = CNT_W'(OVERSAMPLE/2 + 1);

    logic [2:0] samples;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samples <= '0;
        end else if (enable) begin
            if (edge_cnt == EDGE_S0) samples[0] <= RX_IN;
            if (edge_cnt == EDGE_S1) samples[1] <= RX_IN;
            if (edge_cnt == EDGE_S2) samples[2] <= RX_IN;
        end
    end

    assign sampled_bit = maj3(samples);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversampled frame recovery (start, LSB-first data, optional
// parity, one stop) with one-cycle valid/parity/stop result pulses.
module uart_rx_deserializer
    import uart_rx_deserializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input logic                 clk,
    input logic                 rst,
    uart_rx_deserializer_if.slave bus
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] EDGE_LAST   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] EDGE_DECIDE = CNT_W'(OVERSAMPLE/2 + 2);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_WIDTH - 1);

    rx_state_t             state, state_nxt;
    logic [CNT_W-1:0]      edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  par_en_q, par_typ_q, par_bad;
    logic                  dv_q, pe_q, se_q;
    logic                  sampled_bit;
    logic                  start_det, shift_en, par_chk, frame_done;

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE),
        .CNT_W     (CNT_W)
    ) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (bus.RX_IN),
        .edge_cnt   (edge_cnt),
        .enable     (state != IDLE),
        .sampled_bit(sampled_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start_det  = 1'b0;
        shift_en   = 1'b0;
        par_chk    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.RX_IN) begin
                    start_det = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                // A start bit that votes high was only a glitch.
                if (edge_cnt == EDGE_DECIDE && sampled_bit) state_nxt = IDLE;
                else if (edge_cnt == EDGE_LAST)             state_nxt = DATA;
            end
            DATA: begin
                if (edge_cnt == EDGE_LAST) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST) state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (edge_cnt == EDGE_LAST) begin
                    par_chk   = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (edge_cnt == EDGE_LAST) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bad   <= 1'b0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            pe_q <= 1'b0;
            se_q <= 1'b0;

            // The detect cycle counts as edge 0 of the start bit.
            if (start_det) begin
                edge_cnt  <= CNT_W'(1);
                par_en_q  <= bus.PAR_EN;
                par_typ_q <= bus.PAR_TYP;
                par_bad   <= 1'b0;
            end else if (state_nxt == IDLE) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + CNT_W'(1);
            end

            if (state == START)  bit_cnt <= '0;
            else if (shift_en)   bit_cnt <= bit_cnt + BIT_W'(1);

            if (shift_en) shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};

            if (par_chk) par_bad <= (sampled_bit != expected_parity(par_typ_q, ^shift_reg));

            if (frame_done) begin
                se_q <= ~sampled_bit;
                pe_q <= par_bad;
                if (sampled_bit && !par_bad) begin
                    dv_q     <= 1'b1;
                    p_data_q <= shift_reg;
                end
            end
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = dv_q;
    assign bus.par_err    = pe_q;
    assign bus.stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frame table plus hand-written
// sequences for glitches, back-to-back frames, break and mid-frame reset.
module tb_uart_rx_deserializer;
    import uart_rx_deserializer_pkg::*;

    localparam int OS = 8;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_deserializer_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx_deserializer #(
        .DATA_WIDTH(DW),
        .OVERSAMPLE(OS)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] d;
        logic       pen;
        logic       ptyp;
        logic       pbit;
        logic       sbit;
        int         glitch_bit;
        logic       flip;
        int         exp_v;
        int         exp_p;
        int         exp_s;
        logic [7:0] exp_pd;
    } vec_t;

    vec_t vecs[10];

    int cyc = 0;
    int start_edge = 0;
    int n_valid = 0, n_par = 0, n_stp = 0;
    int last_v = 0, prev_v = 0;
    int errors = 0, checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            n_valid = n_valid + 1;
            prev_v  = last_v;
            last_v  = cyc;
        end
        if (bus.par_err === 1'b1) n_par = n_par + 1;
        if (bus.stp_err === 1'b1) n_stp = n_stp + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.RX_IN = 1'b1;
        end
    endtask

    // Drives one frame, one bit per OS cycles. abort_at stops after that many cycles.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic sbit, input int glitch_bit, input logic flip,
                              input int abort_at);
        logic [11:0] fr;
        int nb, k;
        fr = '1;
        fr[0] = 1'b0;
        for (int j = 0; j < 8; j++) fr[1+j] = d[j];
        if (pen) begin
            fr[9]  = pbit;
            fr[10] = sbit;
            nb = 11;
        end else begin
            fr[9] = sbit;
            nb = 10;
        end
        k = 0;
        for (int b = 0; b < nb; b++) begin
            for (int e = 0; e < OS; e++) begin
                if (k == abort_at) return;
                @(negedge clk);
                if (k == 0) start_edge = cyc + 1;
                bus.RX_IN = fr[b] ^ ((glitch_bit >= 0 && b == glitch_bit + 1 && e == OS/2) ? 1'b1 : 1'b0);
                if (flip && b == 1 && e == 0) begin
                    bus.PAR_EN  = ~bus.PAR_EN;
                    bus.PAR_TYP = ~bus.PAR_TYP;
                end
                k++;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int bv, bp, bs;
        bv = n_valid; bp = n_par; bs = n_stp;
        bus.PAR_EN  = v.pen;
        bus.PAR_TYP = v.ptyp;
        send_frame(v.d, v.pen, v.pbit, v.sbit, v.glitch_bit, v.flip, -1);
        idle(4);
        check($sformatf("v%0d data_valid count", idx), n_valid - bv, v.exp_v);
        check($sformatf("v%0d par_err count", idx),    n_par - bp,   v.exp_p);
        check($sformatf("v%0d stp_err count", idx),    n_stp - bs,   v.exp_s);
        check($sformatf("v%0d P_DATA", idx),           int'(bus.P_DATA), int'(v.exp_pd));
        if (v.exp_v == 1)
            check($sformatf("v%0d latency", idx), last_v - start_edge + 1, v.pen ? 88 : 80);
    endtask

    initial begin
        int bv, bp, bs;

        //           d      pen   ptyp  pbit  sbit  glitch flip  v  p  s  pdata
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1, 0, 0, 8'hA5};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1, 0, 0, 8'hA5};
        vecs[2] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0, 0, 1, 0, 8'hA5};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0, 1, 0, 0, 8'h3C};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0, 0, 0, 1, 8'h3C};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0, 0, 1, 1, 8'h3C};
        vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1,  3, 1'b0, 1, 0, 0, 8'h5A};
        vecs[7] = '{8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1, 0, 0, 8'h0F};
        vecs[8] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1, 0, 0, 8'h00};
        vecs[9] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1, 0, 0, 8'hFF};

        bus.RX_IN   = 1'b1;
        bus.PAR_EN  = 1'b0;
        bus.PAR_TYP = 1'b0;
        repeat (3) @(negedge clk);
        check("reset P_DATA",     int'(bus.P_DATA),     0);
        check("reset data_valid", int'(bus.data_valid), 0);
        check("reset par_err",    int'(bus.par_err),    0);
        check("reset stp_err",    int'(bus.stp_err),    0);
        check("reset state",      int'(dut.state),      int'(IDLE));
        rst_n = 1'b1;
        idle(4);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Two-cycle low pulse is rejected as a glitch.
        bv = n_valid; bp = n_par; bs = n_stp;
        @(negedge clk); bus.RX_IN = 1'b0;
        @(negedge clk); bus.RX_IN = 1'b0;
        idle(12);
        check("glitch state", int'(dut.state), int'(IDLE));
        check("glitch pulses", (n_valid - bv) + (n_par - bp) + (n_stp - bs), 0);

        // Back-to-back frames with no idle bit.
        bus.PAR_EN = 1'b0;
        bv = n_valid;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, 1'b0, -1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1, -1, 1'b0, -1);
        idle(4);
        check("b2b valid count", n_valid - bv, 2);
        check("b2b spacing", last_v - prev_v, 80);
        check("b2b P_DATA", int'(bus.P_DATA), 8'hAA);

        // Break: line held low through the stop bit and beyond.
        bv = n_valid; bs = n_stp;
        for (int k = 0; k < 82; k++) begin
            @(negedge clk);
            if (k == 0) start_edge = cyc + 1;
            bus.RX_IN = 1'b0;
        end
        @(negedge clk);
        check("break stp_err count", n_stp - bs, 1);
        check("break valid count", n_valid - bv, 0);
        check("break restart state", int'(dut.state), int'(START));
        check("break P_DATA held", int'(bus.P_DATA), 8'hAA);
        bus.RX_IN = 1'b1;
        idle(20);
        check("break recover state", int'(dut.state), int'(IDLE));
        check("break stp_err final", n_stp - bs, 1);

        // Reset in cycle 40 of a frame.
        bv = n_valid; bp = n_par; bs = n_stp;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, -1, 1'b0, 39);
        @(negedge clk);
        rst_n = 1'b0;
        bus.RX_IN = 1'b1;
        #1;
        check("midrst P_DATA", int'(bus.P_DATA), 0);
        check("midrst state", int'(dut.state), int'(IDLE));
        check("midrst data_valid", int'(bus.data_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(90);
        check("midrst pulses", (n_valid - bv) + (n_par - bp) + (n_stp - bs), 0);
        check("midrst P_DATA after", int'(bus.P_DATA), 0);

        run_vec('{8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1, 0, 0, 8'h7E}, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
